// File: rtl/frame_reader_pkg.sv
// Shared types for the frame reader: FSM states, buffer indexing, log levels.
package frame_reader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_RELEASE,
    ST_CHECK,
    ST_ISSUE,
    ST_RECEIVE,
    ST_FINALIZE
  } fr_state_e;

  localparam int BUFFER_COUNT = 3;

  typedef logic [1:0] buf_idx_t;

  typedef enum int {
    SVL_QUIET        = 0,
    SVL_ERROR        = 1,
    SVL_WARNING      = 2,
    SVL_INFO         = 3,
    SVL_VERBOSE_INFO = 4
  } svl_level_e;

  // Any index outside the buffer range falls back to buffer 0.
  function automatic buf_idx_t sanitize_buf_id(input buf_idx_t id);
    return (int'(id) < BUFFER_COUNT) ? id : buf_idx_t'(0);
  endfunction

endpackage

// File: rtl/buffer_read_client.sv
// Read-side client of the triple-buffer controller: request, grant latch,
// release wait and end-of-frame finalize, all keyed off the reader's state.
module buffer_read_client
  import frame_reader_pkg::*;
#(
  parameter int LOG_LEVEL = SVL_VERBOSE_INFO
) (
  input  logic      clk,
  input  logic      reset_n,
  input  fr_state_e state_i,
  input  logic      buffer_id_valid_i,
  input  buf_idx_t  buffer_id_i,
  output logic      read_rq_rdy_o,
  output logic      finalize_rd_o,
  output logic      grant_o,
  output logic      released_o,
  output buf_idx_t  buf_id_o
);

  buf_idx_t buf_id_q, buf_id_d;

  assign grant_o       = (state_i == ST_REQ) && buffer_id_valid_i;
  assign released_o    = (state_i == ST_RELEASE) && !buffer_id_valid_i;
  assign read_rq_rdy_o = (state_i == ST_REQ);
  assign finalize_rd_o = (state_i == ST_FINALIZE);
  assign buf_id_o      = buf_id_q;

  // Capture the granted buffer, mapping the illegal index 3 to buffer 0.
  always_comb begin
    buf_id_d = buf_id_q;
    if (grant_o) buf_id_d = sanitize_buf_id(buffer_id_i);
  end

  // Latched buffer index register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) buf_id_q <= '0;
    else          buf_id_q <= buf_id_d;
  end

  // Simulation-only report of an out-of-range grant.
  always @(posedge clk) begin
    if (reset_n && grant_o && (LOG_LEVEL >= SVL_ERROR)) begin
      assert (int'(buffer_id_i) < BUFFER_COUNT)
        else $warning("frame_reader: illegal buffer_id %0d granted, using buffer 0", buffer_id_i);
    end
  end

endmodule

// File: rtl/frame_reader.sv
// Reads one frame from a granted frame buffer as a sequence of fixed-length
// memory bursts, forwarding each data beat downstream one cycle later.
module frame_reader
  import frame_reader_pkg::*;
#(
  parameter int FRAME_WORDS   = 4096,
  parameter int BURST_LEN     = 8,
  parameter int ADDR_WIDTH    = 21,
  parameter int BUFFER_STRIDE = 'h10000,
  parameter int LOG_LEVEL     = SVL_VERBOSE_INFO
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  output logic                  read_rq_rdy,
  output logic                  finalize_rd,
  input  logic                  buffer_id_valid,
  input  logic [1:0]            buffer_id,
  output logic                  mem_rd_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_rd_ack,
  input  logic                  mem_data_valid,
  input  logic [31:0]           mem_data,
  input  logic [7:0]            fifo_free,
  output logic                  out_valid,
  output logic [31:0]           out_data,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int OFS_W  = $clog2(FRAME_WORDS + 1);
  localparam int BEAT_W = $clog2(BURST_LEN);
  localparam logic [OFS_W-1:0]  FRAME_END  = OFS_W'(FRAME_WORDS);
  localparam logic [OFS_W-1:0]  BURST_STEP = OFS_W'(BURST_LEN);
  localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(BURST_LEN - 1);
  localparam logic [8:0]        FIFO_NEED  = 9'(BURST_LEN);

  fr_state_e             state_q, state_d;
  logic [OFS_W-1:0]      word_offset_q, word_offset_d;
  logic [BEAT_W-1:0]     beat_cnt_q, beat_cnt_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic                  out_valid_q;
  logic [31:0]           out_data_q;

  logic                  grant, released;
  buf_idx_t              buf_id;
  logic [ADDR_WIDTH-1:0] burst_addr;
  logic [OFS_W-1:0]      next_offset;
  logic                  beat_accept;

  buffer_read_client #(
    .LOG_LEVEL(LOG_LEVEL)
  ) u_client (
    .clk              (clk),
    .reset_n          (reset_n),
    .state_i          (state_q),
    .buffer_id_valid_i(buffer_id_valid),
    .buffer_id_i      (buffer_id),
    .read_rq_rdy_o    (read_rq_rdy),
    .finalize_rd_o    (finalize_rd),
    .grant_o          (grant),
    .released_o       (released),
    .buf_id_o         (buf_id)
  );

  // Address arithmetic wraps naturally at ADDR_WIDTH bits.
  assign burst_addr  = ADDR_WIDTH'(buf_id) * ADDR_WIDTH'(BUFFER_STRIDE)
                     + ADDR_WIDTH'(word_offset_q);
  assign next_offset = word_offset_q + BURST_STEP;
  // A beat arriving together with the burst acceptance is the burst's first beat.
  assign beat_accept = mem_data_valid &&
                       ((state_q == ST_RECEIVE) || ((state_q == ST_ISSUE) && mem_rd_ack));

  // Next-state logic and burst/frame bookkeeping.
  always_comb begin
    state_d       = state_q;
    word_offset_d = word_offset_q;
    beat_cnt_d    = beat_cnt_q;
    mem_addr_d    = mem_addr_q;
    case (state_q)
      ST_IDLE:    if (start) state_d = ST_REQ;
      ST_REQ:     if (grant) state_d = ST_RELEASE;
      ST_RELEASE: if (released) state_d = ST_CHECK;
      ST_CHECK: begin
        if ({1'b0, fifo_free} >= FIFO_NEED) begin
          state_d    = ST_ISSUE;
          mem_addr_d = burst_addr;
          beat_cnt_d = '0;
        end
      end
      ST_ISSUE: begin
        if (mem_rd_ack) begin
          state_d = ST_RECEIVE;
          if (mem_data_valid) beat_cnt_d = BEAT_W'(1);
        end
      end
      ST_RECEIVE: begin
        if (mem_data_valid) begin
          beat_cnt_d = beat_cnt_q + BEAT_W'(1);
          if (beat_cnt_q == LAST_BEAT) begin
            beat_cnt_d    = '0;
            word_offset_d = next_offset;
            state_d       = (next_offset == FRAME_END) ? ST_FINALIZE : ST_CHECK;
          end
        end
      end
      ST_FINALIZE: begin
        word_offset_d = '0;
        state_d       = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      word_offset_q <= '0;
      beat_cnt_q    <= '0;
      mem_addr_q    <= '0;
    end else begin
      state_q       <= state_d;
      word_offset_q <= word_offset_d;
      beat_cnt_q    <= beat_cnt_d;
      mem_addr_q    <= mem_addr_d;
    end
  end

  // One-cycle forwarding of accepted data beats.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= beat_accept;
      if (beat_accept) out_data_q <= mem_data;
    end
  end

  assign mem_rd_req = (state_q == ST_ISSUE);
  assign mem_addr   = mem_addr_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign busy       = (state_q != ST_IDLE);
  assign frame_done = finalize_rd;

endmodule

// File: tb/tb_frame_reader.sv
// Bench for frame_reader: table of frame reads plus hand-written corner
// sequences, with random data/timing checked against an in-order word model.
module tb_frame_reader;

  localparam int FW     = 32;
  localparam int BL     = 8;
  localparam int AW     = 21;
  localparam int STRIDE = 'h10000;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          buffer_id_valid = 1'b0;
  logic [1:0]    buffer_id = 2'd0;
  logic          mem_rd_ack = 1'b0;
  logic          mem_data_valid = 1'b0;
  logic [31:0]   mem_data = 32'd0;
  logic [7:0]    fifo_free = 8'd255;
  logic          read_rq_rdy, finalize_rd, mem_rd_req, out_valid, busy, frame_done;
  logic [AW-1:0] mem_addr;
  logic [31:0]   out_data;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [1:0]    id;
    int            gdly;
    int            adly;
    bit            bwa;
    logic [AW-1:0] exp_base;
  } vec_t;
  vec_t tbl[5];

  frame_reader #(
    .FRAME_WORDS  (FW),
    .BURST_LEN    (BL),
    .ADDR_WIDTH   (AW),
    .BUFFER_STRIDE(STRIDE)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .read_rq_rdy    (read_rq_rdy),
    .finalize_rd    (finalize_rd),
    .buffer_id_valid(buffer_id_valid),
    .buffer_id      (buffer_id),
    .mem_rd_req     (mem_rd_req),
    .mem_addr       (mem_addr),
    .mem_rd_ack     (mem_rd_ack),
    .mem_data_valid (mem_data_valid),
    .mem_data       (mem_data),
    .fifo_free      (fifo_free),
    .out_valid      (out_valid),
    .out_data       (out_data),
    .busy           (busy),
    .frame_done     (frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Buffer base address from the grant rule: index 3 is treated as 0.
  function automatic logic [AW-1:0] base_of(input logic [1:0] id);
    int eff;
    eff = (id == 2'd3) ? 0 : int'(id);
    return AW'(eff * STRIDE);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Advance to the next falling edge and check the output stream there.
  task automatic tick();
    logic [31:0] e;
    @(negedge clk);
    if (out_valid) begin
      if (exp_q.size() == 0) chk("unexpected_out_valid", out_valid, 1'b0);
      else begin
        e = exp_q.pop_front();
        chk("out_data", out_data, e);
      end
    end
    if (frame_done || finalize_rd) begin
      chk("finalize_eq_done", finalize_rd, frame_done);
      if (frame_done) done_cnt++;
    end
  endtask

  task automatic handshake(input logic [1:0] id, input int gdly);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("rq_rdy_on_start", read_rq_rdy, 1'b1);
    chk("busy_on_start", busy, 1'b1);
    for (int i = 0; i < gdly; i++) tick();
    chk("rq_rdy_held", read_rq_rdy, 1'b1);
    buffer_id = id;
    buffer_id_valid = 1'b1;
    tick();
    chk("rq_rdy_drop", read_rq_rdy, 1'b0);
    tick();
    buffer_id_valid = 1'b0;
    buffer_id = 2'($urandom);
  endtask

  // Wait for a burst request, feeding stray data beats that must be ignored.
  task automatic wait_req(output bit ok);
    int n = 0;
    while (!mem_rd_req && n < 60) begin
      mem_data_valid = 1'($urandom_range(0, 1));
      mem_data = $urandom;
      tick();
      n++;
    end
    mem_data_valid = 1'b0;
    ok = mem_rd_req;
    chk("req_seen", mem_rd_req, 1'b1);
  endtask

  task automatic do_burst(input logic [AW-1:0] addr, input int adly, input bit bwa,
                          input int nbeats, output bit ok);
    bit hold_ok = 1'b1;
    bit noreq_ok = 1'b1;
    int sent = 0;
    wait_req(ok);
    if (!ok) return;
    chk("burst_addr", mem_addr, addr);
    for (int i = 0; i < adly; i++) begin
      tick();
      if (!mem_rd_req || mem_addr !== addr) hold_ok = 1'b0;
    end
    if (adly > 0) chk("req_addr_hold", hold_ok, 1'b1);
    mem_rd_ack = 1'b1;
    if (bwa) begin
      mem_data_valid = 1'b1;
      mem_data = $urandom;
      exp_q.push_back(mem_data);
      sent = 1;
    end
    tick();
    mem_rd_ack = 1'b0;
    mem_data_valid = 1'b0;
    while (sent < nbeats) begin
      repeat ($urandom_range(0, 2)) begin
        start = 1'($urandom_range(0, 1));
        mem_data = $urandom;
        tick();
        if (mem_rd_req) noreq_ok = 1'b0;
      end
      start = 1'b0;
      mem_data_valid = 1'b1;
      mem_data = $urandom;
      exp_q.push_back(mem_data);
      sent++;
      tick();
      mem_data_valid = 1'b0;
      if (mem_rd_req) noreq_ok = 1'b0;
    end
    chk("no_req_in_burst", noreq_ok, 1'b1);
  endtask

  task automatic run_frame(input logic [1:0] id, input int gdly, input int adly, input bit bwa,
                           input logic [AW-1:0] base, input int stall);
    int d0;
    bit ok;
    bit stall_ok = 1'b1;
    d0 = done_cnt;
    handshake(id, gdly);
    if (stall > 0) begin
      fifo_free = 8'd7;
      for (int i = 0; i < stall; i++) begin
        tick();
        if (mem_rd_req) stall_ok = 1'b0;
      end
      chk("req_low_while_fifo_short", stall_ok, 1'b1);
      fifo_free = 8'd8;
    end
    for (int b = 0; b < FW / BL; b++) begin
      do_burst(base + AW'(b * BL), adly, bwa, BL, ok);
      if (!ok) break;
    end
    fifo_free = 8'd255;
    chk("frame_done_count", done_cnt - d0, 1);
    chk("words_drained", exp_q.size(), 0);
    exp_q.delete();
    tick();
    chk("busy_after_frame", busy, 1'b0);
    chk("idle_no_request", read_rq_rdy, 1'b0);
  endtask

  initial begin
    int d0;
    bit ok;
    logic [1:0] rid;

    tbl[0] = '{2'd1, 3, 0, 1'b0, 21'h10000};
    tbl[1] = '{2'd2, 0, 0, 1'b0, 21'h20000};
    tbl[2] = '{2'd0, 1, 2, 1'b1, 21'h00000};
    tbl[3] = '{2'd3, 2, 1, 1'b0, 21'h00000};
    tbl[4] = '{2'd2, 0, 5, 1'b1, 21'h20000};

    // Reset state, with start held high to show it has no effect in reset.
    start = 1'b1;
    repeat (3) tick();
    start = 1'b0;
    chk("reset_ctrl_outputs", {read_rq_rdy, finalize_rd, mem_rd_req, out_valid, busy, frame_done}, 6'd0);
    chk("reset_mem_addr", mem_addr, 0);
    chk("reset_out_data", out_data, 0);

    // Release reset; the first frame's start is presented on the same cycle.
    reset_n = 1'b1;
    for (int k = 0; k < 5; k++)
      run_frame(tbl[k].id, tbl[k].gdly, tbl[k].adly, tbl[k].bwa, tbl[k].exp_base, 0);

    // Back-to-back frames on buffers 0, 1, 2.
    d0 = done_cnt;
    for (int k = 0; k < 3; k++) run_frame(2'(k), 1, 0, 1'b0, base_of(2'(k)), 0);
    chk("back_to_back_done", done_cnt - d0, 3);

    // Downstream FIFO too full for 20 cycles before the first burst.
    run_frame(2'd2, 0, 0, 1'b0, 21'h20000, 20);

    // Reset in the middle of the third burst abandons the frame.
    d0 = done_cnt;
    handshake(2'd2, 0);
    do_burst(21'h20000, 0, 1'b0, BL, ok);
    do_burst(21'h20008, 0, 1'b0, BL, ok);
    do_burst(21'h20010, 1, 1'b0, 3, ok);
    reset_n = 1'b0;
    #1;
    chk("async_reset_outputs",
        {read_rq_rdy, finalize_rd, mem_rd_req, out_valid, busy, frame_done, mem_addr, out_data},
        0);
    exp_q.delete();
    tick();
    chk("reset_held_outputs", {read_rq_rdy, finalize_rd, mem_rd_req, out_valid, busy, frame_done}, 6'd0);
    chk("no_finalize_on_reset", done_cnt - d0, 0);
    reset_n = 1'b1;
    run_frame(2'd1, 0, 0, 1'b0, 21'h10000, 0);

    // Randomised frames.
    for (int k = 0; k < 4; k++) begin
      rid = 2'($urandom_range(0, 3));
      run_frame(rid, $urandom_range(0, 4), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                base_of(rid), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/frame_reader.md
FRAME_READER -- requirements
Module: frame_reader

Interface
REQ-001 Param FRAME_WORDS, 4096: 32-bit words per frame; multiple of BURST_LEN.
REQ-002 Param BURST_LEN, 8: words per memory read burst; power of 2, 2..64.
REQ-003 Param ADDR_WIDTH, 21: memory word-address width.
REQ-004 Param BUFFER_STRIDE, 'h10000: word offset between frame buffers 0,1,2.
REQ-005 Param LOG_LEVEL, SVL_VERBOSE_INFO: simulation log verbosity; no synthesis effect.
REQ-006 clk  in  1  block clock, same domain as buffer controller.
REQ-007 reset_n  in  1  asynchronous, active-low reset.
REQ-008 start  in  1  one-cycle pulse requesting one frame read; ignored unless idle.
REQ-009 read_rq_rdy  out  1  read buffer request to buffer controller.
REQ-010 finalize_rd  out  1  one-cycle pulse releasing the read buffer.
REQ-011 buffer_id_valid  in  1  buffer controller grant qualifier.
REQ-012 buffer_id  in  2  granted buffer index, 0..2.
REQ-013 mem_rd_req  out  1  burst read request, held until mem_rd_ack.
REQ-014 mem_addr  out  ADDR_WIDTH  burst start word address, stable while mem_rd_req high.
REQ-015 mem_rd_ack  in  1  one-cycle acceptance of current burst.
REQ-016 mem_data_valid  in  1  read data beat qualifier.
REQ-017 mem_data  in  32  read data beat.
REQ-018 fifo_free  in  8  free words in downstream FIFO.
REQ-019 out_valid  out  1  output word qualifier.
REQ-020 out_data  out  32  output word.
REQ-021 busy  out  1  high in every state except IDLE.
REQ-022 frame_done  out  1  one-cycle pulse, coincident with finalize_rd.

Function
REQ-023 FSM states: IDLE, REQ, RELEASE, CHECK, ISSUE, RECEIVE, FINALIZE.
REQ-024 IDLE: start -> REQ; start outside IDLE is dropped.
REQ-025 REQ: read_rq_rdy=1; when buffer_id_valid=1, latch buffer_id, drop read_rq_rdy next cycle, -> RELEASE.
REQ-026 RELEASE: read_rq_rdy=0; wait buffer_id_valid=0 -> CHECK.
REQ-027 buffer_id=3 at grant is illegal: error logged in simulation; treated as 0.
REQ-028 CHECK: fifo_free >= BURST_LEN -> ISSUE; else hold.
REQ-029 ISSUE: mem_rd_req=1, mem_addr = id*BUFFER_STRIDE + word_offset, truncated to ADDR_WIDTH; mem_rd_ack -> RECEIVE.
REQ-030 RECEIVE: each mem_data_valid beat forwarded next cycle as out_valid/out_data (1-cycle latency); beat counter counts to BURST_LEN.
REQ-031 mem_data_valid outside RECEIVE is ignored and not forwarded.
REQ-032 Burst complete: word_offset += BURST_LEN; if word_offset == FRAME_WORDS -> FINALIZE, else -> CHECK.
REQ-033 mem_data_valid and mem_rd_ack in the same cycle in ISSUE: the beat is counted as beat 0.
REQ-034 FINALIZE: finalize_rd=1 and frame_done=1 for exactly one cycle, word_offset cleared, -> IDLE.
REQ-035 Minimum gap: a start on the cycle after frame_done is accepted.
REQ-036 At most one outstanding burst; no new mem_rd_req before current burst's last beat.

Reset
REQ-037 reset_n low: state IDLE; read_rq_rdy, finalize_rd, mem_rd_req, out_valid, busy, frame_done = 0; mem_addr, out_data, counters, latched id = 0.
REQ-038 Reset mid-frame discards all progress; no finalize_rd is issued for the interrupted frame.
REQ-039 First start after reset release is honoured on the first clk edge.

Structure
REQ-040 Shared package holds the state enum, BUFFER_COUNT=3 and the buffer index type (2 bits).
REQ-041 Buffer controller handshake (REQ/RELEASE/FINALIZE) is one sub-module, buffer_read_client; burst sequencing stays in frame_reader.

Verification
REQ-042 Controller grants 1 after 3 cycles: buffer_id latched 1, first mem_addr='h10000, read_rq_rdy low 1 cycle after grant.
REQ-043 FRAME_WORDS=32, BURST_LEN=8, id 2, fifo_free=255: 4 bursts at 'h20000,'h20008,'h20010,'h20018; 32 out_valid words equal mem_data; single finalize_rd.
REQ-044 fifo_free=7 for 20 cycles then 8: mem_rd_req stays 0 until fifo_free=8, then asserts.
REQ-045 mem_rd_ack delayed 5 cycles: mem_addr and mem_rd_req stable for all 5 cycles.
REQ-046 reset_n low during burst 2: all outputs 0 next cycle, no finalize_rd; next start reads from offset 0.
REQ-047 Three back-to-back frames with controller model grants 0,1,2: three frame_done pulses, addresses based on 0,'h10000,'h20000.
